// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register reader: opcodes, operands,
// instruction words, results and the reader FSM state encoding.
package instr_register_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned COUNT_W = 6;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0]       operand_t;
    typedef logic [ADDR_W-1:0]        address_t;
    typedef logic signed [63:0]       result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic result_t sext(input operand_t v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational arithmetic for one instruction word; all operations are
// carried out at 64 bits so no sum, difference or product loses bits.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter result_t ERR_RESULT = 64'sd0
) (
    input  instruction_t i_instr,
    output result_t      o_result,
    output logic         o_div_err
);

    result_t w_a;
    result_t w_b;

    assign w_a = sext(i_instr.op_a);
    assign w_b = sext(i_instr.op_b);

    // Signed '/' and '%' truncate toward zero; the 64-bit width keeps
    // -2^31 / -1 representable.
    always_comb begin
        o_result  = '0;
        o_div_err = 1'b0;
        case (i_instr.opc)
            ZERO:  o_result = '0;
            PASSA: o_result = w_a;
            PASSB: o_result = w_b;
            ADD:   o_result = w_a + w_b;
            SUB:   o_result = w_a - w_b;
            MULT:  o_result = w_a * w_b;
            DIV: begin
                if (w_b == '0) begin
                    o_result  = ERR_RESULT;
                    o_div_err = 1'b1;
                end else begin
                    o_result = w_a / w_b;
                end
            end
            MOD: begin
                if (w_b == '0) begin
                    o_result  = ERR_RESULT;
                    o_div_err = 1'b1;
                end else begin
                    o_result = w_a % w_b;
                end
            end
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/instr_reader.sv
// Reads a burst of instruction register entries, evaluates each one and
// presents the results one at a time on a valid/ready output.
module instr_reader
    import instr_register_pkg::*;
#(
    parameter result_t ERR_RESULT = 64'sd0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  address_t            first_addr,
    input  logic [COUNT_W-1:0]  count,
    output address_t            read_pointer,
    input  instruction_t        instruction_word,
    output logic                res_valid,
    input  logic                res_ready,
    output address_t            res_addr,
    output opcode_t             res_opcode,
    output result_t             result,
    output logic                div_err,
    output logic                busy,
    output logic                done,
    output state_t              o_dbg_state
);

    state_t             r_state;
    address_t           r_ptr;
    logic [COUNT_W-1:0] r_remaining;
    instruction_t       r_instr;
    logic               r_res_valid;
    result_t            r_result;
    address_t           r_res_addr;
    opcode_t            r_res_opcode;
    logic               r_div_err;
    logic               r_busy;
    logic               r_done;

    result_t            w_alu_result;
    logic               w_alu_err;

    instr_alu #(.ERR_RESULT(ERR_RESULT)) u_alu (
        .i_instr   (r_instr),
        .o_result  (w_alu_result),
        .o_div_err (w_alu_err)
    );

    // Handshake: res_valid stays high with result/res_addr/res_opcode/div_err
    // frozen until a rising edge samples res_ready=1; that edge is the transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_remaining  <= '0;
            r_instr      <= '0;
            r_res_valid  <= 1'b0;
            r_result     <= '0;
            r_res_addr   <= '0;
            r_res_opcode <= ZERO;
            r_div_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            r_ptr       <= first_addr;
                            r_remaining <= count;
                            r_busy      <= 1'b1;
                            r_state     <= FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    r_instr <= instruction_word;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result     <= w_alu_result;
                    r_div_err    <= w_alu_err;
                    r_res_opcode <= r_instr.opc;
                    r_res_addr   <= r_ptr;
                    r_res_valid  <= 1'b1;
                    r_state      <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_remaining <= r_remaining - 6'd1;
                        if (r_remaining == 6'd1) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            // 5-bit pointer wraps 31 -> 0 naturally
                            r_ptr   <= r_ptr + 5'd1;
                            r_state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign read_pointer = r_ptr;
    assign res_valid    = r_res_valid;
    assign res_addr     = r_res_addr;
    assign res_opcode   = r_res_opcode;
    assign result       = r_result;
    assign div_err      = r_div_err;
    assign busy         = r_busy;
    assign done         = r_done;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_instr_reader.sv
// Directed vector bench for instr_reader: single-entry bursts from a table,
// then wrap, backpressure, zero-count and mid-burst reset sequences.
module tb_instr_reader;
    import instr_register_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    address_t      first_addr;
    logic [5:0]    count;
    address_t      read_pointer;
    instruction_t  instruction_word;
    logic          res_valid;
    logic          res_ready;
    address_t      res_addr;
    opcode_t       res_opcode;
    result_t       result;
    logic          div_err;
    logic          busy;
    logic          done;
    state_t        dbg_state;

    instruction_t  mem [32];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]         addr;
        logic [3:0]         opc;
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic signed [63:0] exp_res;
        logic               exp_err;
    } vec_t;

    vec_t vecs [15];

    instr_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_addr         (res_addr),
        .res_opcode       (res_opcode),
        .result           (result),
        .div_err          (div_err),
        .busy             (busy),
        .done             (done),
        .o_dbg_state      (dbg_state)
    );

    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [4:0] addr, input logic [3:0] opc,
                           input logic signed [31:0] a, input logic signed [31:0] b,
                           input logic signed [63:0] exp_res, input logic exp_err);
        vecs[i].addr    = addr;
        vecs[i].opc     = opc;
        vecs[i].a       = a;
        vecs[i].b       = b;
        vecs[i].exp_res = exp_res;
        vecs[i].exp_err = exp_err;
    endtask

    task automatic load(input logic [4:0] addr, input logic [3:0] opc,
                        input logic signed [31:0] a, input logic signed [31:0] b);
        mem[addr].opc  = opcode_t'(opc);
        mem[addr].op_a = a;
        mem[addr].op_b = b;
    endtask

    // Called at a negedge: raise start now, return at the negedge where
    // res_valid is first seen (or the cycle budget runs out).
    task automatic launch(input logic [4:0] addr, input logic [5:0] cnt, output int lat);
        first_addr = addr;
        count      = cnt;
        start      = 1'b1;
        lat        = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
            if (res_valid === 1'b1) break;
        end
    endtask

    initial begin
        int          lat;
        int          n_hs;
        logic [4:0]  exp_q[$];
        logic [4:0]  got_q[$];
        logic [4:0]  wrap_addrs [4];

        reset      = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        count      = '0;
        res_ready  = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // ADD, MULT, DIV, MOD-by-zero, then edge cases
        set_vec(0,  5'd0,  4'd3, 32'sd5,          -32'sd7,         -64'sd2,                  1'b0);
        set_vec(1,  5'd3,  4'd5, 32'sh7FFFFFFF,   32'sd2,          64'sh00000000FFFFFFFE,    1'b0);
        set_vec(2,  5'd4,  4'd6, -32'sd7,         32'sd2,          -64'sd3,                  1'b0);
        set_vec(3,  5'd5,  4'd7, -32'sd7,         32'sd0,          64'sd0,                   1'b1);
        set_vec(4,  5'd6,  4'd4, 32'sh80000000,   32'sd1,          -64'sd2147483649,         1'b0);
        set_vec(5,  5'd7,  4'd1, -32'sd100,       32'sd9,          -64'sd100,                1'b0);
        set_vec(6,  5'd8,  4'd2, 32'sd3,          -32'sd1,         -64'sd1,                  1'b0);
        set_vec(7,  5'd9,  4'd0, 32'sd11,         32'sd12,         64'sd0,                   1'b0);
        set_vec(8,  5'd10, 4'd7, -32'sd7,         32'sd2,          -64'sd1,                  1'b0);
        set_vec(9,  5'd11, 4'd6, 32'sd7,          32'sd0,          64'sd0,                   1'b1);
        set_vec(10, 5'd12, 4'd6, 32'sh80000000,   -32'sd1,         64'sd2147483648,          1'b0);
        set_vec(11, 5'd13, 4'hF, 32'sd5,          32'sd5,          64'sd0,                   1'b0);
        set_vec(12, 5'd14, 4'd5, 32'sh80000000,   32'sh80000000,   64'sh4000000000000000,    1'b0);
        set_vec(13, 5'd15, 4'd3, 32'sh7FFFFFFF,   32'sh7FFFFFFF,   64'sd4294967294,          1'b0);
        set_vec(14, 5'd31, 4'd4, 32'sd3,          32'sd10,         -64'sd7,                  1'b0);
        for (int i = 0; i < 15; i++) load(vecs[i].addr, vecs[i].opc, vecs[i].a, vecs[i].b);

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_read_pointer", read_pointer, 0);
        check("rst_res_valid",    res_valid,    0);
        check("rst_result",       result,       0);
        check("rst_res_addr",     res_addr,     0);
        check("rst_res_opcode",   res_opcode,   ZERO);
        check("rst_div_err",      div_err,      0);
        check("rst_busy",         busy,         0);
        check("rst_done",         done,         0);
        check("rst_state",        dbg_state,    IDLE);
        reset = 1'b0;

        // Table: one-entry bursts, res_ready held high
        res_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            launch(vecs[i].addr, 6'd1, lat);
            check($sformatf("v%0d_latency", i),   lat,       3);
            check($sformatf("v%0d_res_valid", i), res_valid, 1);
            check($sformatf("v%0d_busy", i),      busy,      1);
            check($sformatf("v%0d_result", i),    result,    vecs[i].exp_res);
            check($sformatf("v%0d_div_err", i),   div_err,   vecs[i].exp_err);
            check($sformatf("v%0d_res_addr", i),  res_addr,  vecs[i].addr);
            check($sformatf("v%0d_opcode", i),    res_opcode, vecs[i].opc);
            @(negedge clk);
            check($sformatf("v%0d_done", i),      done,      1);
            check($sformatf("v%0d_valid_drop", i), res_valid, 0);
            check($sformatf("v%0d_busy_done", i), busy,      0);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), done,     0);
        end

        // Wrap: 30, 31, 0, 1
        wrap_addrs = '{5'd30, 5'd31, 5'd0, 5'd1};
        foreach (wrap_addrs[j]) begin
            load(wrap_addrs[j], 4'd1, 32'sd1000 + 32'(wrap_addrs[j]), 32'sd0);
            exp_q.push_back(wrap_addrs[j]);
        end
        @(negedge clk);
        first_addr = 5'd30;
        count      = 6'd4;
        start      = 1'b1;
        n_hs       = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (res_valid === 1'b1) begin
                got_q.push_back(res_addr);
                check($sformatf("wrap_result_%0d", n_hs), result, 64'sd1000 + 64'(exp_q[n_hs % 4]));
                n_hs++;
            end
            if (done === 1'b1) break;
        end
        check("wrap_done_seen", done, 1);
        check("wrap_count", got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            check($sformatf("wrap_addr_%0d", j), got_q[j], exp_q[j]);

        // Backpressure: two entries, first held for several cycles
        load(5'd10, 4'd3, 32'sd1, 32'sd2);
        load(5'd11, 4'd4, 32'sd1, 32'sd2);
        res_ready = 1'b0;
        @(negedge clk);
        launch(5'd10, 6'd2, lat);
        check("bp_latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", k),  res_valid,    1);
            check($sformatf("bp_result_%0d", k), result,       3);
            check($sformatf("bp_addr_%0d", k),   res_addr,     10);
            check($sformatf("bp_rdptr_%0d", k),  read_pointer, 10);
            check($sformatf("bp_state_%0d", k),  dbg_state,    OUT);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_adv_valid", res_valid,    0);
        check("bp_adv_rdptr", read_pointer, 11);
        check("bp_adv_state", dbg_state,    FETCH);
        @(negedge clk);
        @(negedge clk);
        check("bp_second_valid",  res_valid, 1);
        check("bp_second_result", result,    -1);
        check("bp_second_addr",   res_addr,  11);
        @(negedge clk);
        check("bp_done", done, 1);
        check("bp_rdptr_hold", read_pointer, 11);

        // Zero count goes straight to DONE
        @(negedge clk);
        first_addr = 5'd20;
        count      = 6'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zc_done",  done,      1);
        check("zc_busy",  busy,      0);
        check("zc_valid", res_valid, 0);
        check("zc_state", dbg_state, DONE);
        check("zc_rdptr", read_pointer, 11);
        @(negedge clk);
        check("zc_done_pulse", done,      0);
        check("zc_idle",       dbg_state, IDLE);

        // Reset in EXEC of an 8-entry burst, then a normal burst
        load(5'd0, 4'd3, 32'sd5, -32'sd7);
        @(negedge clk);
        first_addr = 5'd0;
        count      = 6'd8;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mr_fetch", dbg_state, FETCH);
        @(negedge clk);
        check("mr_exec", dbg_state, EXEC);
        #1 reset = 1'b1;
        #1;
        check("mr_busy",  busy,      0);
        check("mr_valid", res_valid, 0);
        check("mr_state", dbg_state, IDLE);
        @(negedge clk);
        reset = 1'b0;
        launch(5'd0, 6'd1, lat);
        check("mr_latency", lat,       3);
        check("mr_result",  result,    -2);
        check("mr_addr",    res_addr,  0);
        @(negedge clk);
        check("mr_done", done, 1);
        @(negedge clk);
        check("mr_idle", dbg_state, IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_reader.md
INSTR_READER -- requirements
Module: instr_reader

Interface
REQ-001 SHALL have parameter ERR_RESULT, default 64'sd0, value driven on result for divide/modulo by zero.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a read burst.
REQ-005 SHALL have port first_addr, input, address_t (5), first register entry to read.
REQ-006 SHALL have port count, input, 6, entries to read (0..32).
REQ-007 SHALL have port read_pointer, output, address_t (5), read address to the instruction register.
REQ-008 SHALL have port instruction_word, input, instruction_t, combinational read data for read_pointer.
REQ-009 SHALL have ports res_valid, output, 1, and res_ready, input, 1; result handshake.
REQ-010 SHALL have ports res_addr, output, address_t, and res_opcode, output, opcode_t; source entry and opcode of the result.
REQ-011 SHALL have port result, output, result_t (signed 64), computed value.
REQ-012 SHALL have port div_err, output, 1, high with result when a DIV/MOD divisor is 0.
REQ-013 SHALL have ports busy, output, 1, and done, output, 1; burst active and one-cycle burst-complete pulse.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, EXEC, OUT, DONE.
REQ-015 IDLE: start=1 with count>0 -> FETCH; latch first_addr into the pointer and count into the remaining-count register; start with count=0 -> DONE.
REQ-016 FETCH: drive read_pointer = pointer; capture instruction_word at the clock edge -> EXEC.
REQ-017 EXEC: compute the result from the captured word into the output registers -> OUT; res_valid rises the next cycle.
REQ-018 Latency: start-to-first res_valid is exactly 3 cycles.
REQ-019 OUT: res_valid=1; result, res_addr, res_opcode, div_err stable until res_ready=1 is sampled.
REQ-020 OUT with res_ready=1: decrement remaining; if remaining becomes 0 -> DONE, else increment the pointer -> FETCH.
REQ-021 The pointer SHALL wrap modulo 32 (31 -> 0).
REQ-022 DONE: done=1 for exactly one cycle -> IDLE.
REQ-023 busy SHALL be 1 in FETCH, EXEC, OUT; 0 in IDLE and DONE.
REQ-024 start SHALL be ignored while not in IDLE.
REQ-025 Arithmetic: ZERO=0; PASSA/PASSB=sign-extended operand; ADD/SUB=sign-extended 64-bit, no overflow loss; MULT=full 64-bit signed product.
REQ-026 DIV/MOD SHALL use signed truncation toward zero; divisor 0 -> result=ERR_RESULT, div_err=1.
REQ-027 Undefined opcode encodings SHALL produce result=0 with div_err=0.
REQ-028 read_pointer SHALL hold its last value outside FETCH.

Reset
REQ-029 reset=1 SHALL force IDLE immediately, without waiting for clk, including mid-burst.
REQ-030 Reset values SHALL be: read_pointer=0, res_valid=0, result=0, res_addr=0, res_opcode=ZERO, div_err=0, busy=0, done=0, internal counters 0.
REQ-031 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-032 opcode_t, operand_t (signed 32), address_t, instruction_t and new result_t (signed 64) SHALL live in instr_register_pkg.
REQ-033 Arithmetic SHALL be a combinational sub-module instr_alu (instruction_t in; result_t and div_err out).

Verification
REQ-034 Load entry 0 = ADD, a=5, b=-7; start, first_addr=0, count=1, res_ready=1 -> res_valid on cycle 3, result=-2, res_addr=0, done one cycle after the handshake.
REQ-035 Entry 3 = MULT, a=32'h7FFFFFFF, b=2 -> result=64'sh00000000FFFFFFFE.
REQ-036 Entry 4 = DIV, a=-7, b=2 -> result=-3; entry 5 = MOD, a=-7, b=0 -> result=0, div_err=1.
REQ-037 first_addr=30, count=4, res_ready=1 -> res_addr sequence 30, 31, 0, 1, then done.
REQ-038 Hold res_ready=0 for 5 cycles in OUT -> res_valid and result stable; no pointer advance; advance the cycle after res_ready=1.
REQ-039 Assert reset mid-burst (in EXEC, count=8) -> busy=0 and res_valid=0 immediately; the next start with count=1 completes normally.
